// File: rtl/compare_nbit_seq_if.sv
// Start/done handshake bundle for the chunked magnitude comparator.
// Master issues operands; slave returns busy/done and the result flags.
interface compare_nbit_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             esit;
  logic             buyuk;
  logic             kucuk;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, esit, buyuk, kucuk
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, esit, buyuk, kucuk
  );
endinterface

// File: rtl/compare_nbit_seq.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock,
// with early exit on the first differing chunk.
module compare_nbit_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                clk,
  input logic                rst_n,
  compare_nbit_seq_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  if ((WIDTH < 1) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad
    $error("compare_nbit_seq: WIDTH must be a nonzero multiple of CHUNK");
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             esit_q, esit_d;
  logic             buyuk_q, buyuk_d;
  logic             kucuk_q, kucuk_d;

  logic [CHUNK-1:0] ca, cb;

  assign ca = sa_q[WIDTH-1 -: CHUNK];
  assign cb = sb_q[WIDTH-1 -: CHUNK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      esit_q  <= 1'b0;
      buyuk_q <= 1'b0;
      kucuk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      esit_q  <= esit_d;
      buyuk_q <= buyuk_d;
      kucuk_q <= kucuk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    esit_d  = esit_q;
    buyuk_d = buyuk_q;
    kucuk_d = kucuk_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Flipping the sign bit maps signed order onto unsigned order.
          sa_d    = bus.signed_mode ? (bus.a ^ MSB) : bus.a;
          sb_d    = bus.signed_mode ? (bus.b ^ MSB) : bus.b;
          cnt_d   = '0;
          esit_d  = 1'b0;
          buyuk_d = 1'b0;
          kucuk_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ca != cb) begin
          buyuk_d = (ca > cb);
          kucuk_d = (ca < cb);
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          esit_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          sa_d  = sa_q << CHUNK;
          sb_d  = sb_q << CHUNK;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.esit  = esit_q;
  assign bus.buyuk = buyuk_q;
  assign bus.kucuk = kucuk_q;
endmodule

// File: tb/tb_compare_nbit_seq.sv
// Directed bench for compare_nbit_seq at WIDTH=16, CHUNK=4.
// Expected latencies and flags are hand-derived per vector.
module tb_compare_nbit_seq;
  logic clk;
  logic rst_n;
  int   vec;
  int   mis;
  int   n;
  int   bc;
  int   dseen;

  compare_nbit_seq_if #(.WIDTH(16)) bus ();

  compare_nbit_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic e,
                         input logic g, input logic l);
    chk({tag, ".esit"},  32'(bus.esit),  32'(e));
    chk({tag, ".buyuk"}, 32'(bus.buyuk), 32'(g));
    chk({tag, ".kucuk"}, 32'(bus.kucuk), 32'(l));
  endtask

  // Drive a request, cross E0, and confirm the accept state.
  task automatic launch(input string tag, input logic [15:0] av,
                        input logic [15:0] bv, input logic m);
    bus.a = av;
    bus.b = bv;
    bus.signed_mode = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = ~av;
    bus.b = ~bv;
    bus.signed_mode = ~m;
    chk({tag, ".busy0"}, 32'(bus.busy), 32'd1);
    chk({tag, ".done0"}, 32'(bus.done), 32'd0);
    chk_res({tag, ".clr"}, 1'b0, 1'b0, 1'b0);
  endtask

  // Counts edges until done; busy cycles include the one after E0.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges = 99;
    busy_cyc = 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        edges = i;
        break;
      end
      if (bus.busy) busy_cyc++;
    end
  endtask

  task automatic after_done(input string tag, input logic e,
                            input logic g, input logic l);
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, 32'(bus.done), 32'd0);
    chk_res({tag, ".hold"}, e, g, l);
  endtask

  initial begin
    vec = 0;
    mis = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a = '0;
    bus.b = '0;

    // Reset with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'($urandom);
      bus.signed_mode = 1'($urandom);
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
    end
    @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk_res("rst", 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    dseen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dseen++;
    end
    chk("idle.nodone", 32'(dseen), 32'd0);
    chk("idle.busy", 32'(bus.busy), 32'd0);

    // Equal operands: full NCHUNK latency.
    launch("eq", 16'h1234, 16'h1234, 1'b0);
    wait_done(n, bc);
    chk("eq.lat", 32'(n), 32'd4);
    chk("eq.busycyc", 32'(bc), 32'd4);
    chk("eq.busy", 32'(bus.busy), 32'd0);
    chk_res("eq", 1'b1, 1'b0, 1'b0);
    after_done("eq", 1'b1, 1'b0, 1'b0);

    launch("u8000", 16'h8000, 16'h7FFF, 1'b0);
    wait_done(n, bc);
    chk("u8000.lat", 32'(n), 32'd1);
    chk_res("u8000", 1'b0, 1'b1, 1'b0);
    after_done("u8000", 1'b0, 1'b1, 1'b0);

    launch("s8000", 16'h8000, 16'h7FFF, 1'b1);
    wait_done(n, bc);
    chk("s8000.lat", 32'(n), 32'd1);
    chk_res("s8000", 1'b0, 1'b0, 1'b1);

    launch("sFFFF", 16'hFFFF, 16'h0001, 1'b1);
    wait_done(n, bc);
    chk("sFFFF.lat", 32'(n), 32'd1);
    chk_res("sFFFF", 1'b0, 1'b0, 1'b1);

    launch("late", 16'h1235, 16'h1234, 1'b0);
    wait_done(n, bc);
    chk("late.lat", 32'(n), 32'd4);
    chk_res("late", 1'b0, 1'b1, 1'b0);
    after_done("late", 1'b0, 1'b1, 1'b0);

    // Start pulsed at E2 of a running compare must be ignored.
    launch("ign", 16'h1235, 16'h1234, 1'b0);
    @(posedge clk);
    #1;
    bus.a = 16'h0000;
    bus.b = 16'hFFFF;
    bus.signed_mode = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("ign.busy", 32'(bus.busy), 32'd1);
    wait_done(n, bc);
    chk("ign.lat", 32'(n), 32'd2);
    chk_res("ign", 1'b0, 1'b1, 1'b0);

    // Back-to-back: start in the done cycle.
    bus.a = 16'h0001;
    bus.b = 16'h0002;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b.done0", 32'(bus.done), 32'd0);
    chk("b2b.busy0", 32'(bus.busy), 32'd1);
    chk_res("b2b.clr", 1'b0, 1'b0, 1'b0);
    wait_done(n, bc);
    chk("b2b.lat", 32'(n), 32'd4);
    chk_res("b2b", 1'b0, 1'b0, 1'b1);
    after_done("b2b", 1'b0, 1'b0, 1'b1);

    // Reset mid-operation aborts without done.
    launch("mid", 16'h1234, 16'h1234, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid.busy", 32'(bus.busy), 32'd0);
    chk("mid.done", 32'(bus.done), 32'd0);
    chk_res("mid", 1'b0, 1'b0, 1'b0);
    dseen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dseen++;
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dseen++;
    end
    chk("mid.nodone", 32'(dseen), 32'd0);

    launch("post", 16'h00A0, 16'h00B0, 1'b0);
    wait_done(n, bc);
    chk("post.lat", 32'(n), 32'd3);
    chk_res("post", 1'b0, 1'b0, 1'b1);
    after_done("post", 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/compare_nbit_seq.md
# compare_nbit_seq

Parametrised, multi-cycle magnitude comparator. It is the N-bit successor of the team's 1-bit equal/greater/less comparator. It compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and terminates early on the first differing chunk. Both unsigned and two's-complement signed comparison are supported. The block serves datapaths that need area-cheap wide comparisons behind a start/done handshake.

## Interface
- WIDTH, default 16: operand width in bits; must be ≥ 1.
- CHUNK, default 4: bits compared per cycle. WIDTH % CHUNK must be 0, otherwise elaboration fails. NCHUNK = WIDTH/CHUNK.
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- start  in  1: request; sampled only while busy=0.
- signed_mode  in  1: 1 selects two's-complement compare, 0 selects unsigned; sampled with start.
- a  in  WIDTH: operand A; sampled with start.
- b  in  WIDTH: operand B; sampled with start.
- busy  out  1: high while a comparison is in progress.
- done  out  1: one-cycle pulse when a result is valid.
- esit  out  1: A == B; held until the next accepted start.
- buyuk  out  1: A > B; held until the next accepted start.
- kucuk  out  1: A < B; held until the next accepted start.

## Operation
- FSM states: IDLE and RUN.
- IDLE:
  - On an edge with start=1, capture a and b into shift registers sa and sb.
  - If signed_mode=1, invert bit WIDTH-1 of both captured operands. This offset-binary trick makes the signed compare an unsigned compare.
  - Clear the chunk counter, clear esit/buyuk/kucuk, and go to RUN.
- RUN, each cycle:
  - Compare sa[WIDTH-1 -: CHUNK] against sb[WIDTH-1 -: CHUNK] as unsigned values.
  - Chunks differ: on the edge, set buyuk or kucuk per that chunk, pulse done, go to IDLE.
  - Chunks equal and counter == NCHUNK-1: set esit, pulse done, go to IDLE.
  - Otherwise: shift sa and sb left by CHUNK, increment the counter, stay in RUN.
- Exactly one of esit/buyuk/kucuk is 1 after any done. All three are 0 between an accepted start and its done.
- start while busy=1 is ignored; operands and mode are not re-sampled.
- a, b and signed_mode may change freely after capture without affecting the result.
- CHUNK == WIDTH gives single-cycle evaluation (NCHUNK=1).
- The counter width is clog2(NCHUNK), minimum 1 bit; no wrap is possible inside RUN.

## Timing
- Reset values, applied while rst_n=0: busy=0, done=0, esit=0, buyuk=0, kucuk=0, FSM=IDLE.
- Asserting rst_n mid-RUN aborts the operation with no done pulse. Operation resumes in IDLE on the first edge after rst_n=1.
- Let E0 be the edge on which start is accepted.
  - busy=1 after E0.
  - The result is registered at edge Ek, where k is the 1-based index of the first differing chunk (MSB chunk = 1), or k = NCHUNK if A == B.
  - After Ek: done=1 for exactly one cycle, busy=0, and the result is valid.
- Latency: min 1 cycle, max NCHUNK cycles.
- Back-to-back operation: a start high during the done cycle (busy=0) is accepted at that edge. Result outputs clear after that edge; done drops.
- done never asserts without a preceding accepted start.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.

- Reset: hold rst_n=0 with random inputs -> busy=0, done=0, esit=0, buyuk=0, kucuk=0. Release, idle 5 cycles -> no done.
- Equal operands: a=0x1234, b=0x1234, signed_mode=0 -> done at E4, esit=1, buyuk=0, kucuk=0. busy high for exactly 4 cycles.
- Early termination:
  - a=0x8000, b=0x7FFF, unsigned -> done at E1, buyuk=1.
  - Same operands, signed -> done at E1, kucuk=1.
  - a=0xFFFF, b=0x0001, signed -> done at E1, kucuk=1.
- Late difference: a=0x1235, b=0x1234, unsigned -> done at E4, buyuk=1.
- Handshake:
  - Pulse start again at E2 of a running compare -> ignored; original result unchanged.
  - Assert start in the done cycle with a=0x0001, b=0x0002 -> accepted; outputs clear; done at E4 with kucuk=1.
- Reset mid-operation: start a=0x1234, b=0x1234, drop rst_n after E2 -> outputs 0, no done. After release, a new compare completes normally.
